// File: rtl/multibit_fifo_pkg.sv
// Shared types and helpers for the round-robin arbiter that feeds the
// source side of the multibit CDC FIFO synchronizer.
package multibit_fifo_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Round-robin pointer after a grant to gnt_id ends: the next requester, wrapping to 0.
    function automatic int unsigned next_rr_ptr(input int unsigned gnt_id,
                                                input int unsigned num_req);
        return (gnt_id + 1 >= num_req) ? 0 : gnt_id + 1;
    endfunction

endpackage

// File: rtl/multibit_fifo_rr_pick.sv
// Combinational rotating-priority encoder: returns the first set bit of req
// found when scanning upward from start and wrapping NUM_REQ-1 -> 0.
module multibit_fifo_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // req rotated so that bit 0 corresponds to the requester at start.
    logic [NUM_REQ-1:0] rot;

    assign rot = NUM_REQ'({req, req} >> start);

    // Lowest set bit of the rotated vector wins; map it back to an absolute index.
    // NOTE: found/idx get defaults before the loop so no path leaves them unassigned (no latch).
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                idx   = IDX_W'((int'(start) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/multibit_fifo_rr_arbiter.sv
// Round-robin arbiter in the source clock domain that shares one multibit CDC
// FIFO synchronizer among NUM_REQ requesters. A grant lasts up to MAX_BURST
// beats; each accepted beat lands in a single output holding stage tagged
// with the requester ID.
module multibit_fifo_rr_arbiter
    import multibit_fifo_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 2,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_en,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic                          m_valid,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [ID_WIDTH-1:0]           m_id,
    input  logic                          m_ready,
    output logic                          busy
);

    // Wide enough to count up to MAX_BURST beats.
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    arb_state_e             state, state_d;
    logic [ID_WIDTH-1:0]    rr_ptr, rr_ptr_d;
    logic [ID_WIDTH-1:0]    gnt_id, gnt_id_d;
    logic [BURST_W-1:0]     burst_cnt, burst_cnt_d;
    logic                   pick_found;
    logic [ID_WIDTH-1:0]    pick_idx;
    logic                   accept;
    logic                   grant_done;
    logic [DATA_WIDTH-1:0]  gnt_data;

    multibit_fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_WIDTH)
    ) u_pick (
        .req   (s_valid & req_en),
        .start (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign gnt_data = s_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    assign busy     = !reset && (state == ARB_GRANT || m_valid);

    // Next-state logic: pick a winner in IDLE, stream its beats in GRANT until a release condition.
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        gnt_id_d    = gnt_id;
        burst_cnt_d = burst_cnt;
        s_ready     = '0;
        accept      = 1'b0;
        grant_done  = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d     = ARB_GRANT;
                    gnt_id_d    = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            ARB_GRANT: begin
                // Ready does not look at s_valid, only at room in the output stage.
                s_ready[gnt_id] = (!m_valid || m_ready) && req_en[gnt_id];
                accept          = s_ready[gnt_id] && s_valid[gnt_id];
                if (!s_valid[gnt_id] || !req_en[gnt_id]) begin
                    // Requester went idle or was masked: give up the grant without a beat.
                    grant_done = 1'b1;
                end else if (accept) begin
                    burst_cnt_d = burst_cnt + 1'b1;
                    if (burst_cnt == BURST_W'(MAX_BURST - 1)) begin
                        grant_done = 1'b1;
                    end
                end
                if (grant_done) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = ID_WIDTH'(next_rr_ptr(32'(gnt_id), 32'(NUM_REQ)));
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (reset) begin
            s_ready = '0;
            accept  = 1'b0;
        end
    end

    // Arbiter state registers.
    // NOTE: flops use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            gnt_id    <= gnt_id_d;
            burst_cnt <= burst_cnt_d;
        end
    end

    // Output holding stage: load on accept (replacing any departing beat), drain on m_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_id    <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= gnt_data;
            m_id    <= gnt_id;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multibit_fifo_rr_arbiter.sv
// Self-checking bench for multibit_fifo_rr_arbiter: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_multibit_fifo_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 2;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_en = '0;
    logic [N-1:0]  s_valid = '0;
    logic [N*DW-1:0] s_data = '0;
    logic [N-1:0]  s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_id;
    logic          m_ready = 1'b0;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multibit_fifo_rr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req_en  (req_en),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_id    (m_id),
        .m_ready (m_ready),
        .busy    (busy)
    );

    // Move to 1 time unit after the next rising edge; inputs are driven here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = '0;
        req_en  = '0;
        m_ready = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bit got = 0;
        reset = 1'b1; s_valid = 4'hF; req_en = 4'hF; m_ready = 1'b1;
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (m_valid !== 1'b0 || s_ready !== 4'h0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold c%0d: m_valid=%b s_ready=%b busy=%b, want 0 0000 0",
                         c, m_valid, s_ready, busy);
            end
            next_cycle();
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (m_valid === 1'b1) begin got = 1; break; end
            next_cycle();
        end
        n_tests++;
        if (!got || m_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_grant: seen=%0d m_id=%0d, want seen=1 m_id=0", got, m_id);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_en = 4'hF; s_valid = 4'b0100; m_ready = 1'b1;
        s_data = '0; s_data[2*DW +: DW] = 32'hA5A5_0001;
        #1;
        n_tests++;
        if (s_ready !== 4'b0000) begin
            n_fail++; $display("FAIL single_c0_ready: got %b want 0000", s_ready);
        end
        next_cycle(); #1;
        n_tests++;
        if (s_ready !== 4'b0100 || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_c1: s_ready=%b m_valid=%b want 0100 0", s_ready, m_valid);
        end
        next_cycle();
        s_data[2*DW +: DW] = 32'hA5A5_0002;
        #1;
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 32'hA5A5_0001 || m_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_c2: m_valid=%b m_data=%h m_id=%0d want 1 a5a50001 2", m_valid, m_data, m_id);
        end
        n_tests++;
        if (s_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_c2_ready: got %b want 0100", s_ready);
        end
        next_cycle(); #1;
        n_tests++;
        if (s_ready !== 4'b0000 || m_valid !== 1'b1 || m_data !== 32'hA5A5_0002) begin
            n_fail++;
            $display("FAIL single_release: s_ready=%b m_valid=%b m_data=%h want 0000 1 a5a50002",
                     s_ready, m_valid, m_data);
        end
    endtask

    task automatic test_all_contend();
        int ids[$];
        int when[$];
        do_reset();
        req_en = 4'hF; s_valid = 4'hF; m_ready = 1'b1;
        for (int i = 0; i < N; i++) s_data[i*DW +: DW] = 32'hC0DE_0000 + i;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_valid === 1'b1) begin
                ids.push_back(int'(m_id));
                when.push_back(c);
                n_tests++;
                if (m_data !== 32'hC0DE_0000 + 32'(m_id)) begin
                    n_fail++; $display("FAIL contend_data c%0d: got %h for id %0d", c, m_data, m_id);
                end
            end
            next_cycle();
        end
        n_tests++;
        if (ids.size() < 10) begin
            n_fail++; $display("FAIL contend_count: got %0d beats want >=10", ids.size());
        end
        for (int k = 0; k < 10 && k < ids.size(); k++) begin
            n_tests++;
            if (ids[k] != (k / 2) % N || when[k] != 2 + 3 * (k / 2) + (k % 2)) begin
                n_fail++;
                $display("FAIL contend_seq k%0d: id=%0d cycle=%0d want id=%0d cycle=%0d",
                         k, ids[k], when[k], (k / 2) % N, 2 + 3 * (k / 2) + (k % 2));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_en = 4'hF; s_valid = 4'b0001; m_ready = 1'b1;
        s_data = '0; s_data[0 +: DW] = 32'hD000_0000;
        next_cycle();
        next_cycle();
        m_ready = 1'b0;
        s_data[0 +: DW] = 32'hD000_0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== 32'hD000_0000 || m_id !== 2'd0 || s_ready !== 4'h0) begin
                n_fail++;
                $display("FAIL bp_hold c%0d: m_valid=%b m_data=%h m_id=%0d s_ready=%b want 1 d0000000 0 0000",
                         c, m_valid, m_data, m_id, s_ready);
            end
            next_cycle();
        end
        m_ready = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 4'b0001 || m_data !== 32'hD000_0000) begin
            n_fail++; $display("FAIL bp_release_ready: s_ready=%b m_data=%h want 0001 d0000000", s_ready, m_data);
        end
        next_cycle(); #1;
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 32'hD000_0001) begin
            n_fail++; $display("FAIL bp_next_beat: m_valid=%b m_data=%h want 1 d0000001", m_valid, m_data);
        end
    endtask

    task automatic test_masking();
        int ids[$];
        do_reset();
        req_en = 4'b1010; s_valid = 4'hF; m_ready = 1'b1;
        for (int i = 0; i < N; i++) s_data[i*DW +: DW] = 32'hBEEF_0000 + i;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_valid === 1'b1) ids.push_back(int'(m_id));
            next_cycle();
        end
        n_tests++;
        if (ids.size() < 6) begin
            n_fail++; $display("FAIL mask_count: got %0d beats want >=6", ids.size());
        end
        for (int k = 0; k < ids.size(); k++) begin
            n_tests++;
            if (ids[k] != (((k / 2) % 2 == 1) ? 3 : 1)) begin
                n_fail++; $display("FAIL mask_seq k%0d: id=%0d want %0d", k, ids[k], ((k / 2) % 2 == 1) ? 3 : 1);
            end
        end
        // Disable requester 1 in the first cycle of its grant.
        do_reset();
        req_en = 4'b1010; s_valid = 4'hF; m_ready = 1'b1;
        next_cycle();
        req_en = 4'b1000;
        #1;
        n_tests++;
        if (s_ready !== 4'b0000) begin
            n_fail++; $display("FAIL mask_drop_ready: got %b want 0000", s_ready);
        end
        next_cycle(); #1;
        n_tests++;
        if (m_valid !== 1'b0 || s_ready !== 4'b0000) begin
            n_fail++; $display("FAIL mask_no_beat: m_valid=%b s_ready=%b want 0 0000", m_valid, s_ready);
        end
        next_cycle(); #1;
        n_tests++;
        if (s_ready !== 4'b1000) begin
            n_fail++; $display("FAIL mask_grant3: s_ready=%b want 1000", s_ready);
        end
        next_cycle(); #1;
        n_tests++;
        if (m_valid !== 1'b1 || m_id !== 2'd3) begin
            n_fail++; $display("FAIL mask_beat3: m_valid=%b m_id=%0d want 1 3", m_valid, m_id);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit got = 0;
        do_reset();
        req_en = 4'hF; s_valid = 4'b0100; m_ready = 1'b1;
        s_data = '0; s_data[2*DW +: DW] = 32'h2222_0001;
        next_cycle();
        next_cycle();
        #1;
        n_tests++;
        if (m_valid !== 1'b1 || m_id !== 2'd2) begin
            n_fail++; $display("FAIL rst_mid_pre: m_valid=%b m_id=%0d want 1 2", m_valid, m_id);
        end
        reset = 1'b1; s_valid = 4'hF;
        #1;
        n_tests++;
        if (s_ready !== 4'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_gate: s_ready=%b busy=%b want 0000 0", s_ready, busy);
        end
        next_cycle(); #1;
        n_tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: m_valid=%b busy=%b s_ready=%b want 0 0 0000", m_valid, busy, s_ready);
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            next_cycle(); #1;
            if (m_valid === 1'b1) begin got = 1; break; end
        end
        n_tests++;
        if (!got || m_id !== 2'd0) begin
            n_fail++; $display("FAIL rst_mid_first_grant: seen=%0d m_id=%0d want seen=1 m_id=0", got, m_id);
        end
    endtask

    // Randomized traffic against a rule-level model: who owns the channel, how
    // many beats it has sent, where the next search starts, and the held beat.
    task automatic test_random();
        bit            granted = 0;
        int            owner = 0;
        int            beats = 0;
        int            ptr = 0;
        bit            ov = 0;
        logic [DW-1:0] od = '0;
        int            oid = 0;
        logic [N-1:0]  exp_ready;
        bit            exp_busy;
        bit            take;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset   = ($urandom_range(0, 59) == 0);
            req_en  = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF;
            s_valid = N'($urandom) | N'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) s_data[i*DW +: DW] = $urandom;
            #1;
            exp_ready = '0;
            if (!reset && granted && req_en[owner] && (!ov || m_ready)) exp_ready[owner] = 1'b1;
            exp_busy = !reset && (granted || ov);
            n_tests++;
            if (s_ready !== exp_ready || busy !== exp_busy || m_valid !== ov) begin
                n_fail++;
                $display("FAIL rand_ctrl c%0d: s_ready=%b busy=%b m_valid=%b want %b %b %b",
                         c, s_ready, busy, m_valid, exp_ready, exp_busy, ov);
            end
            if (ov) begin
                n_tests++;
                if (m_data !== od || m_id !== IW'(oid)) begin
                    n_fail++;
                    $display("FAIL rand_data c%0d: m_data=%h m_id=%0d want %h %0d", c, m_data, m_id, od, oid);
                end
            end
            if (reset) begin
                granted = 0; owner = 0; beats = 0; ptr = 0; ov = 0; od = '0; oid = 0;
            end else begin
                take = granted && exp_ready[owner] && s_valid[owner];
                if (take) begin
                    ov = 1; od = s_data[owner*DW +: DW]; oid = owner;
                end else if (m_ready) begin
                    ov = 0;
                end
                if (!granted) begin
                    for (int k = 0; k < N; k++) begin
                        int j = (ptr + k) % N;
                        if (!granted && s_valid[j] && req_en[j]) begin
                            granted = 1; owner = j; beats = 0;
                        end
                    end
                end else if (!s_valid[owner] || !req_en[owner]) begin
                    granted = 0; ptr = (owner + 1) % N;
                end else if (take) begin
                    beats++;
                    if (beats == MB) begin
                        granted = 0; ptr = (owner + 1) % N;
                    end
                end
            end
            next_cycle();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_contend();
        test_backpressure();
        test_masking();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multibit_fifo_rr_arbiter.md
Name: multibit_fifo_rr_arbiter

Overview:
- Round-robin arbiter that shares the source side of one multibit CDC FIFO synchronizer among NUM_REQ requesters.
- Grants one requester at a time, for up to MAX_BURST beats.
- Registers the winning beat into a single output holding stage, tagged with the requester ID.
- Sits in the source clock domain, directly in front of the synchronizer's avalid/adata/aready.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 32, payload width per beat.
- MAX_BURST, 2, maximum consecutive beats per grant (≥1).
- ID_WIDTH, $clog2(NUM_REQ), derived localparam; width of requester ID.

Ports:
- clk  in  1  block clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- req_en  in  NUM_REQ  per-requester enable mask; 0 excludes the requester from arbitration.
- s_valid  in  NUM_REQ  per-requester beat valid.
- s_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_ready  out  NUM_REQ  per-requester accept.
- m_valid  out  1  output beat valid; drives synchronizer avalid.
- m_data  out  DATA_WIDTH  output payload; drives synchronizer adata.
- m_id  out  ID_WIDTH  index of the requester that sourced m_data.
- m_ready  in  1  downstream accept; driven from synchronizer aready.
- busy  out  1  high when state==ARB_GRANT or m_valid==1.

Behaviour:
- A beat transfers on s_valid[i]&s_ready[i] or on m_valid&m_ready, at the rising clk edge.
- Reset (synchronous, any time, including mid-burst):
  - All flops clear on the next edge: state=ARB_IDLE, rr_ptr=0, gnt_id=0, burst_cnt=0, m_valid=0, m_data=0, m_id=0.
  - s_ready=0 and busy=0 while reset is high.
  - A beat held in the output stage is dropped; the requester does not get it back.
- State machine:
  - ARB_IDLE:
    - eligible = s_valid & req_en.
    - If eligible≠0, the rotating search starts at rr_ptr and wraps NUM_REQ-1→0; the first set bit becomes gnt_id.
    - Next state ARB_GRANT, burst_cnt=0.
    - s_ready=0 in ARB_IDLE.
  - ARB_GRANT:
    - s_ready[gnt_id] = s_valid-independent (!m_valid | m_ready) & req_en[gnt_id]; all other s_ready bits are 0.
    - On accept: m_data←s_data[gnt_id], m_id←gnt_id, m_valid←1, burst_cnt++.
- Grant release (ARB_GRANT→ARB_IDLE next edge, rr_ptr←(gnt_id+1) mod NUM_REQ):
  - (a) A beat is accepted with burst_cnt==MAX_BURST-1.
  - (b) s_valid[gnt_id]==0 this cycle; no beat is taken.
  - (c) req_en[gnt_id]==0 this cycle; no beat is taken.
- Output stage:
  - m_valid clears on m_ready when no new beat is loaded in the same cycle.
  - Simultaneous m_ready and new accept: the new beat replaces the old one; m_valid stays 1.
  - While m_valid & !m_ready, m_data and m_id are held stable.
- Latency:
  - s_valid rises in ARB_IDLE at cycle 0 → s_ready at cycle 1 → m_valid at cycle 2.
  - One ARB_IDLE bubble cycle occurs between consecutive grants.
- Back-to-back beats within a burst run at full rate while m_ready=1.
- Fairness: a continuously-valid enabled requester is granted within NUM_REQ-1 other grants.
- An s_valid drop mid-burst (case b) ends the grant. The requester must re-win arbitration.

Decomposition:
- Package multibit_fifo_pkg:
  - typedef enum logic [0:0] arb_state_e {ARB_IDLE, ARB_GRANT}.
  - Function next_rr_ptr(gnt_id, NUM_REQ).
- Sub-module multibit_fifo_rr_pick: combinational rotating-priority encoder.
  - Inputs: req vector, start pointer.
  - Outputs: found, idx.
  - The arbiter instantiates it once.

Test Plan:
- Reset: hold reset 3 cycles with s_valid=4'hF, req_en=4'hF → m_valid=0, s_ready=0, busy=0 throughout. First grant after release is m_id=0.
- Single requester: s_valid=4'b0100, s_data lane2=32'hA5A5_0001, m_ready=1 → s_ready=4'b0100 at cycle 1; m_valid=1, m_data=32'hA5A5_0001, m_id=2 at cycle 2. Release after 2 beats.
- All contend: s_valid=4'hF, req_en=4'hF, m_ready=1, MAX_BURST=2 → m_id sequence 0,0,1,1,2,2,3,3,0,0, with one bubble between bursts.
- Backpressure: m_ready=0 for 5 cycles while m_valid=1 → m_data/m_id stable, s_ready=0. m_ready=1 → the next beat follows the next cycle.
- Masking: req_en=4'b1010, s_valid=4'hF → only m_id 1 and 3 alternate.
  - Clearing req_en[1] during 1's grant takes no beat that cycle and grants 3 next.
- Reset mid-burst: assert reset while m_valid=1, gnt_id=2 → m_valid=0 next edge. After release with s_valid=4'hF, the first grant is m_id=0.
